// File: rtl/hanoi_pkg.sv
// Shared types and helpers for the Tower-of-Hanoi move generator.
// The peg rotation helper is fixed at 2 bits because only three pegs are supported.
package hanoi_pkg;

   typedef enum logic [1:0] {IDLE, MOVE, DONE} state_t;

   function automatic int unsigned ring_w(input int unsigned m);
      return $clog2(m);
   endfunction

   // A single ring still needs a 1-bit index port.
   function automatic int unsigned ind_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // dir_up rotates 0->1->2->0; otherwise the rotation is 0->2->1->0.
   function automatic logic [1:0] next_peg(input logic [1:0] peg, input logic dir_up);
      logic [1:0] r;
      if (dir_up) begin
         r = (peg == 2'd2) ? 2'd0 : peg + 2'd1;
      end else begin
         r = (peg == 2'd0) ? 2'd2 : peg - 2'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/hanoi_ctz.sv
// Trailing-zero count of the move index; selects the ring to move.
// An all-zero index yields 0.
module hanoi_ctz
   import hanoi_pkg::*;
#(
   parameter int unsigned N = 3
) (
   input  logic [N-1:0]           i_k,
   output logic [ind_w(N)-1:0]    o_ctz
);

   localparam int unsigned CW = ind_w(N);

   // Scan from the top so the lowest set bit wins.
   always_comb begin
      o_ctz = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (i_k[i]) o_ctz = CW'(i);
      end
   end

endmodule

// File: rtl/hanoi_solver.sv
// Emits the optimal Tower-of-Hanoi move sequence (peg 0 to peg 2) to the board and
// cross-checks a local mirror of ring locations against the board every cycle.
module hanoi_solver
   import hanoi_pkg::*;
#(
   parameter int unsigned N = 3,
   parameter int unsigned M = 3
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_start,
   input  logic                      i_move_ready,
   input  logic [N*ring_w(M)-1:0]    i_rings,
   output logic                      o_move_valid,
   output logic [ind_w(N)-1:0]       o_ind,
   output logic [ring_w(M)-1:0]      o_loc,
   output logic                      o_busy,
   output logic                      o_done,
   output logic [N-1:0]              o_move_cnt,
   output logic                      o_err
);

   localparam int unsigned W  = ring_w(M);
   localparam int unsigned IW = ind_w(N);
   localparam logic [N-1:0] KLast = '1;

   if (M != 3) begin : g_bad_m
      $error("hanoi_solver supports only M == 3");
   end

   state_t              r_state;
   state_t              w_state_next;
   logic [N-1:0]        r_k;
   logic [N-1:0]        r_move_cnt;
   logic [N-1:0][W-1:0] r_mirror;
   logic                r_err;
   logic [IW-1:0]       w_d;
   logic [W-1:0]        w_loc;
   logic                w_dir_up;
   logic                w_transfer;
   logic                w_accept;
   logic                w_last;

   hanoi_ctz #(
      .N(N)
   ) u_ctz (
      .i_k   (r_k),
      .o_ctz (w_d)
   );

   // Ring d rotates upward when N-d is even, i.e. when N and d share parity.
   assign w_dir_up   = (1'(N % 2) == w_d[0]);
   assign w_loc      = next_peg(r_mirror[w_d], w_dir_up);
   assign w_transfer = (r_state == MOVE) && i_move_ready;
   assign w_accept   = i_start && ((r_state == IDLE) || (r_state == DONE));
   assign w_last     = (r_k == KLast);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         IDLE, DONE: if (i_start) w_state_next = MOVE;
         MOVE:       if (w_transfer && w_last) w_state_next = DONE;
         default:    w_state_next = IDLE;
      endcase
   end

   always_comb begin
      o_move_valid = 1'b0;
      o_ind        = '0;
      o_loc        = '0;
      o_busy       = 1'b0;
      o_done       = 1'b0;
      unique case (r_state)
         MOVE: begin
            o_move_valid = 1'b1;
            o_ind        = w_d;
            o_loc        = w_loc;
            o_busy       = 1'b1;
         end
         DONE:    o_done = 1'b1;
         default: ;
      endcase
   end

   // k holds at its last value in DONE instead of wrapping.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_mirror   <= '0;
         r_k        <= N'(1);
         r_move_cnt <= '0;
         r_err      <= 1'b0;
      end else if (w_accept) begin
         r_mirror   <= '0;
         r_k        <= N'(1);
         r_move_cnt <= '0;
         r_err      <= 1'b0;
      end else begin
         if (w_transfer) begin
            r_mirror[w_d] <= w_loc;
            r_move_cnt    <= r_move_cnt + N'(1);
            if (!w_last) r_k <= r_k + N'(1);
         end
         if ((r_state != IDLE) && (i_rings != r_mirror)) r_err <= 1'b1;
      end
   end

   assign o_move_cnt = r_move_cnt;
   assign o_err      = r_err;

endmodule

// File: tb/tb_hanoi_solver.sv
// Bench for hanoi_solver: behavioural boards, expected-move scoreboards for N=3, N=1, N=4.
module tb_hanoi_solver;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_val(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference move tables (ring, destination peg) worked out from the recursive solution.
   localparam int E3_IND [7]  = '{0, 1, 0, 2, 0, 1, 0};
   localparam int E3_LOC [7]  = '{2, 1, 1, 2, 0, 2, 2};
   localparam int E4_IND [15] = '{0, 1, 0, 2, 0, 1, 0, 3, 0, 1, 0, 2, 0, 1, 0};
   localparam int E4_LOC [15] = '{1, 2, 2, 1, 0, 1, 1, 2, 2, 0, 0, 2, 1, 2, 2};

   logic rst, start3, start_x, rdy3, brd_rst3;
   logic [5:0] corrupt3;

   logic [2:0][1:0] board3;
   logic [5:0]      rings3;
   logic            mv3, busy3, done3, err3;
   logic [1:0]      ind3, loc3;
   logic [2:0]      cnt3;

   logic [0:0][1:0] board1;
   logic            mv1, busy1, done1, err1;
   logic [0:0]      ind1, cnt1;
   logic [1:0]      loc1;

   logic [3:0][1:0] board4;
   logic            mv4, busy4, done4, err4;
   logic [1:0]      ind4, loc4;
   logic [3:0]      cnt4;

   assign rings3 = board3 ^ corrupt3;

   hanoi_solver #(.N(3), .M(3)) u_dut3 (
      .i_clk(clk), .i_rst(rst), .i_start(start3), .i_move_ready(rdy3), .i_rings(rings3),
      .o_move_valid(mv3), .o_ind(ind3), .o_loc(loc3), .o_busy(busy3), .o_done(done3),
      .o_move_cnt(cnt3), .o_err(err3)
   );

   hanoi_solver #(.N(1), .M(3)) u_dut1 (
      .i_clk(clk), .i_rst(rst), .i_start(start_x), .i_move_ready(1'b1), .i_rings(board1),
      .o_move_valid(mv1), .o_ind(ind1), .o_loc(loc1), .o_busy(busy1), .o_done(done1),
      .o_move_cnt(cnt1), .o_err(err1)
   );

   hanoi_solver #(.N(4), .M(3)) u_dut4 (
      .i_clk(clk), .i_rst(rst), .i_start(start_x), .i_move_ready(1'b1), .i_rings(board4),
      .o_move_valid(mv4), .o_ind(ind4), .o_loc(loc4), .o_busy(busy4), .o_done(done4),
      .o_move_cnt(cnt4), .o_err(err4)
   );

   // Boards register a move on the same edge as the handshake.
   always @(posedge clk) begin
      if (brd_rst3) board3 <= '0;
      else if (mv3 && rdy3) board3[ind3] <= loc3;
      if (rst) begin
         board1 <= '0;
         board4 <= '0;
      end else begin
         if (mv1) board1[0] <= loc1;
         if (mv4) board4[ind4] <= loc4;
      end
   end

   int q3[$];
   int q1[$];
   int q4[$];
   bit stall_q = 1'b0;
   int stall_ind, stall_loc;

   always @(negedge clk) begin
      if (!rst) begin
         if (stall_q && mv3) begin
            check_val("n3_hold_ind", int'(ind3), stall_ind);
            check_val("n3_hold_loc", int'(loc3), stall_loc);
         end
         if (mv3 && rdy3) begin
            check_val("n3_move_expected", int'(q3.size() != 0), 1);
            if (q3.size() != 0) check_val("n3_move", int'(ind3) * 4 + int'(loc3), q3.pop_front());
         end
         stall_q   = mv3 && !rdy3;
         stall_ind = int'(ind3);
         stall_loc = int'(loc3);
         if (mv1) begin
            check_val("n1_move_expected", int'(q1.size() != 0), 1);
            if (q1.size() != 0) check_val("n1_move", int'(ind1) * 4 + int'(loc1), q1.pop_front());
         end
         if (mv4) begin
            check_val("n4_move_expected", int'(q4.size() != 0), 1);
            if (q4.size() != 0) check_val("n4_move", int'(ind4) * 4 + int'(loc4), q4.pop_front());
         end
      end else begin
         stall_q = 1'b0;
      end
   end

   task automatic start_n3();
      @(posedge clk); #1;
      start3 = 1'b1;
      for (int i = 0; i < 7; i++) q3.push_back(E3_IND[i] * 4 + E3_LOC[i]);
      @(posedge clk); #1;
      start3 = 1'b0;
   endtask

   task automatic board_reset3();
      @(posedge clk); #1;
      brd_rst3 = 1'b1;
      @(posedge clk); #1;
      brd_rst3 = 1'b0;
   endtask

   // mode 0: ready held 1; mode 1: ready toggles 1,0,0,1; mode 2: start pulsed mid-solve.
   task automatic run3(input int mode, input bit chk_first, output int busy_cyc);
      bit fin = 1'b0;
      busy_cyc = 0;
      for (int c = 0; c < 100 && !fin; c++) begin
         @(negedge clk);
         if (c == 0 && chk_first) check_val("n3_first_valid", int'(mv3), 1);
         if (done3) begin
            fin = 1'b1;
         end else begin
            if (busy3) busy_cyc++;
            @(posedge clk); #1;
            rdy3   = (mode == 1) ? (((c + 1) % 4 == 0) || ((c + 1) % 4 == 3)) : 1'b1;
            start3 = (mode == 2) && (c == 1);
         end
      end
      rdy3   = 1'b1;
      start3 = 1'b0;
      check_val("n3_done_reached", int'(fin), 1);
   endtask

   task automatic final3(input string p);
      check_val({p, "_done"}, int'(done3), 1);
      check_val({p, "_valid"}, int'(mv3), 0);
      check_val({p, "_rings"}, int'(rings3), 6'b101010);
      check_val({p, "_cnt"}, int'(cnt3), 7);
      check_val({p, "_err"}, int'(err3), 0);
      check_val({p, "_queue_left"}, q3.size(), 0);
   endtask

   task automatic check_idle3(input string p);
      check_val({p, "_valid"}, int'(mv3), 0);
      check_val({p, "_ind"}, int'(ind3), 0);
      check_val({p, "_loc"}, int'(loc3), 0);
      check_val({p, "_busy"}, int'(busy3), 0);
      check_val({p, "_done"}, int'(done3), 0);
      check_val({p, "_cnt"}, int'(cnt3), 0);
      check_val({p, "_err"}, int'(err3), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int busy;
      rst      = 1'b1;
      brd_rst3 = 1'b1;
      start3   = 1'b0;
      start_x  = 1'b0;
      rdy3     = 1'b1;
      corrupt3 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle3("reset");
      @(posedge clk); #1;
      rst      = 1'b0;
      brd_rst3 = 1'b0;

      // Plain solve.
      start_n3();
      run3(0, 1'b1, busy);
      check_val("t1_busy_cycles", busy, 7);
      final3("t1");

      // Backpressure.
      board_reset3();
      start_n3();
      run3(1, 1'b1, busy);
      final3("t2");

      // One-cycle board corruption.
      board_reset3();
      start_n3();
      @(posedge clk); #1;
      corrupt3 = 6'b000001;
      @(negedge clk);
      check_val("t3_err_before", int'(err3), 0);
      @(posedge clk); #1;
      corrupt3 = '0;
      @(negedge clk);
      check_val("t3_err_after", int'(err3), 1);
      run3(0, 1'b0, busy);
      check_val("t3_err_in_done", int'(err3), 1);
      board_reset3();
      start_n3();
      @(negedge clk);
      check_val("t3_err_cleared", int'(err3), 0);
      run3(0, 1'b0, busy);
      final3("t3");

      // Reset after the third transfer.
      board_reset3();
      start_n3();
      for (int c = 0; c < 20 && cnt3 != 3'd3; c++) @(negedge clk);
      check_val("t4_cnt_before_rst", int'(cnt3), 3);
      rst      = 1'b1;
      brd_rst3 = 1'b1;
      @(negedge clk);
      check_idle3("t4_rst");
      q3.delete();
      @(posedge clk); #1;
      rst      = 1'b0;
      brd_rst3 = 1'b0;
      start_n3();
      run3(0, 1'b1, busy);
      check_val("t4_busy_cycles", busy, 7);
      final3("t4");

      // Restart from DONE with a stale board, then a clean restart with start pulsed mid-solve.
      start_n3();
      run3(0, 1'b1, busy);
      check_val("t5_stale_err", int'(err3), 1);
      check_val("t5_stale_cnt", int'(cnt3), 7);
      board_reset3();
      start_n3();
      run3(2, 1'b1, busy);
      check_val("t5_busy_cycles", busy, 7);
      final3("t5");

      // Other ring counts.
      @(posedge clk); #1;
      start_x = 1'b1;
      q1.push_back(0 * 4 + 2);
      for (int i = 0; i < 15; i++) q4.push_back(E4_IND[i] * 4 + E4_LOC[i]);
      @(posedge clk); #1;
      start_x = 1'b0;
      for (int c = 0; c < 40 && !(done1 && done4); c++) @(negedge clk);
      check_val("n1_done", int'(done1), 1);
      check_val("n1_cnt", int'(cnt1), 1);
      check_val("n1_rings", int'(board1), 2);
      check_val("n1_err", int'(err1), 0);
      check_val("n1_queue_left", q1.size(), 0);
      check_val("n4_done", int'(done4), 1);
      check_val("n4_cnt", int'(cnt4), 15);
      check_val("n4_rings", int'(board4), 8'b10101010);
      check_val("n4_err", int'(err4), 0);
      check_val("n4_queue_left", q4.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
